// File: rtl/alu_exec_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_stage
// Description : Two-entry pipelined execute stage. S1 (ID/EX) latches the
//               decoded operands and ALU control code, S2 (EX/WB) holds the
//               ALU result toward write-back behind a valid/ready handshake.
//               Supports streaming, back-pressure and synchronous flush.
//               Optional status flags: define ALU_EX_FLAGS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_stage #(
    parameter int DATA_W  = 16,
    parameter int RADDR_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_alu_ctrl,
    input  logic [DATA_W-1:0]  in_op_a,
    input  logic [DATA_W-1:0]  in_op_b,
    input  logic [RADDR_W-1:0] in_rd,
    input  logic               in_wr_en,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_result,
    output logic [RADDR_W-1:0] out_rd,
    output logic               out_wr_en,
    output logic               out_zero,
    output logic               out_carry,
    output logic               out_ovf
);

    localparam logic [1:0] C_OP_ADD = 2'b00;
    localparam logic [1:0] C_OP_SUB = 2'b01;
    localparam logic [1:0] C_OP_AND = 2'b10;
    localparam logic [1:0] C_OP_OR  = 2'b11;

    // S1 (ID/EX) registers
    logic               r_v1;
    logic [1:0]         r_ctrl;
    logic [DATA_W-1:0]  r_op_a;
    logic [DATA_W-1:0]  r_op_b;
    logic [RADDR_W-1:0] r_rd1;
    logic               r_wr_en1;

    // S2 (EX/WB) registers
    logic               r_v2;
    logic [DATA_W-1:0]  r_result;
    logic [RADDR_W-1:0] r_rd2;
    logic               r_wr_en2;

    // Handshake: S2 can take a new entry when empty or being drained
    logic w_s2_free;
    logic w_adv;
    logic w_accept;

    assign w_s2_free = !r_v2 || out_ready;
    assign w_adv     = r_v1 && w_s2_free;
    assign in_ready  = (!r_v1 || w_adv) && !flush;
    assign w_accept  = in_valid && in_ready;

    // ALU datapath: SUB is done as a + ~b + 1 so one adder serves both
    logic              w_sub;
    logic [DATA_W-1:0] w_b_eff;
    logic [DATA_W-1:0] w_alu;

    assign w_sub   = (r_ctrl == C_OP_SUB);
    assign w_b_eff = w_sub ? ~r_op_b : r_op_b;

`ifdef ALU_EX_FLAGS_EN
    // Extra sum bit is kept only when the carry flag is needed
    logic [DATA_W:0] w_sum;
    assign w_sum = {1'b0, r_op_a} + {1'b0, w_b_eff} + {{DATA_W{1'b0}}, w_sub};
`else
    logic [DATA_W-1:0] w_sum;
    assign w_sum = r_op_a + w_b_eff + {{(DATA_W-1){1'b0}}, w_sub};
`endif

    // Result select by ALU control code
    always_comb begin
        w_alu = w_sum[DATA_W-1:0];
        case (r_ctrl)
            C_OP_ADD: w_alu = w_sum[DATA_W-1:0];
            C_OP_SUB: w_alu = w_sum[DATA_W-1:0];
            C_OP_AND: w_alu = r_op_a & r_op_b;
            C_OP_OR:  w_alu = r_op_a | r_op_b;
            default:  w_alu = w_sum[DATA_W-1:0];
        endcase
    end

    // S1 valid and payload; flush overrides any accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1     <= 1'b0;
            r_ctrl   <= 2'b00;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_rd1    <= '0;
            r_wr_en1 <= 1'b0;
        end else begin
            if (flush)
                r_v1 <= 1'b0;
            else if (w_accept)
                r_v1 <= 1'b1;
            else if (w_adv)
                r_v1 <= 1'b0;

            if (w_accept) begin
                r_ctrl   <= in_alu_ctrl;
                r_op_a   <= in_op_a;
                r_op_b   <= in_op_b;
                r_rd1    <= in_rd;
                r_wr_en1 <= in_wr_en;
            end
        end
    end

    // S2 valid and payload; a result shown alongside flush is not consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2     <= 1'b0;
            r_result <= '0;
            r_rd2    <= '0;
            r_wr_en2 <= 1'b0;
        end else begin
            if (flush)
                r_v2 <= 1'b0;
            else if (w_adv)
                r_v2 <= 1'b1;
            else if (out_ready)
                r_v2 <= 1'b0;

            if (w_adv && !flush) begin
                r_result <= w_alu;
                r_rd2    <= r_rd1;
                r_wr_en2 <= r_wr_en1;
            end
        end
    end

`ifdef ALU_EX_FLAGS_EN
    logic w_arith;
    logic w_zero;
    logic w_carry;
    logic w_ovf;
    logic r_zero;
    logic r_carry;
    logic r_ovf;

    // Overflow: operands (after inversion for SUB) agree in sign, sum does not
    assign w_arith = !r_ctrl[1];
    assign w_zero  = (w_alu == '0);
    assign w_carry = w_arith && w_sum[DATA_W];
    assign w_ovf   = w_arith && (r_op_a[DATA_W-1] == w_b_eff[DATA_W-1])
                             && (w_sum[DATA_W-1] != r_op_a[DATA_W-1]);

    // Status flags travel with the result in S2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zero  <= 1'b0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_adv && !flush) begin
            r_zero  <= w_zero;
            r_carry <= w_carry;
            r_ovf   <= w_ovf;
        end
    end

    assign out_zero  = r_zero;
    assign out_carry = r_carry;
    assign out_ovf   = r_ovf;
`else
    assign out_zero  = 1'b0;
    assign out_carry = 1'b0;
    assign out_ovf   = 1'b0;
`endif

    assign out_valid  = r_v2;
    assign out_result = r_result;
    assign out_rd     = r_rd2;
    assign out_wr_en  = r_wr_en2;

endmodule
`default_nettype wire

// File: doc/alu_exec_stage.md
# alu_exec_stage

Two-entry pipelined execute stage of the 16-bit RISC datapath, directly downstream of the ALU-control decoder. It latches decoded operands and the 2-bit ALU control code (ID/EX register), computes the result, and holds it in an EX/WB register with a valid/ready handshake toward write-back. It supports full-throughput streaming, back-pressure stalls, and a synchronous pipeline flush for branch redirects.

## Interface
- `DATA_W`, 16, operand/result width
- `RADDR_W`, 3, destination register index width (8-entry register file)

- `clk` input 1: rising-edge clock
- `rst_n` input 1: asynchronous, active-low reset
- `in_valid` input 1: upstream presents an instruction
- `in_ready` output 1: stage accepts the instruction this cycle
- `in_alu_ctrl` input 2: 00 ADD, 01 SUB, 10 AND, 11 OR
- `in_op_a`, `in_op_b` input DATA_W: source operands
- `in_rd` input RADDR_W: destination register
- `in_wr_en` input 1: instruction writes the register file
- `flush` input 1: synchronous kill of all in-flight instructions
- `out_valid` output 1: result available
- `out_ready` input 1: write-back consumes the result
- `out_result` output DATA_W: ALU result
- `out_rd` output RADDR_W, `out_wr_en` output 1: forwarded from the input
- `out_zero`, `out_carry`, `out_ovf` output 1: status flags (see Configuration)

## Operation
- S1 (ID/EX): regs `v1`, ctrl, op_a, op_b, rd, wr_en. S2 (EX/WB): regs `v2`, result, rd, wr_en, flags.
- ALU is combinational between S1 and S2:
  - ADD: a+b mod 2^16
  - SUB: a+~b+1 mod 2^16
  - AND: a&b
  - OR: a|b
- `s2_free = !v2 || out_ready`; `adv = v1 && s2_free`; `in_ready = (!v1 || adv) && !flush`.
- Accept when `in_valid && in_ready`: S1 loads the inputs, `v1`=1. If `adv` occurs without an accept, `v1`=0.
- On `adv`: S2 loads the ALU result and S1 sidecar fields, `v2`=1. If `out_ready && v2` with no `adv`, `v2`=0.
- When `v2 && !out_ready`, S2 holds all fields stable. S1 holds too if occupied, and `in_ready`=0 when both are full.
- `flush`: next edge clears `v1` and `v2`. Data regs may keep stale values. Flush overrides accept, advance, and consume in the same cycle. A result presented alongside flush counts as not consumed.
- Payload regs load only on their enable. `out_*` data is meaningful only while `out_valid`=1.
- `out_valid` = `v2`. `out_wr_en` is registered as given and is not qualified by `v2`. Consumers must gate it with `out_valid`.
- Asynchronous reset clears `v1`, `v2`, and all payload regs to 0 at any time, including mid-stall. Outputs read 0 while `rst_n`=0.

## Timing
- Reset values: `in_ready`=1 (unless `flush`), `out_valid`=0, `out_result`=0, `out_rd`=0, `out_wr_en`=0, all flags 0.
- Latency: accepted at edge N → `out_valid`=1 after edge N+1 when unstalled (2 edges).
- Throughput: 1 instruction/cycle with `out_ready` held 1.
- `in_ready` is combinational from `out_ready` and `flush` only; there is no combinational path from `in_*` to `out_*`.
- Capacity: 2 instructions. No instruction is dropped or duplicated under any `out_ready` pattern.

## Configuration
- Macro: `ALU_EX_FLAGS_EN`.
- Defined: S2 registers the flags alongside the result.
  - `out_zero` = (result==0).
  - `out_carry` = bit 16 of the 17-bit ADD/SUB sum (SUB: 1 = no borrow); 0 for AND/OR.
  - `out_ovf` = signed overflow of ADD/SUB; 0 for AND/OR.
- Undefined: the flag registers and logic are removed. `out_zero`, `out_carry`, and `out_ovf` remain as ports tied to 0.

## Test plan
- Reset mid-stall: fill both stages with `out_ready`=0, pulse `rst_n` low asynchronously → `out_valid`=0 and `in_ready`=1 immediately; after release, the first new accept appears 2 edges later.
- Streaming: ADD 0x0003+0x0004, SUB 0x0005−0x0007, AND 0xF0F0&0x0FF0, OR 0x00F0|0x0F00 back-to-back with `out_ready`=1 → results in order 0x0007, 0xFFFE, 0x00F0, 0x0FF0, one per cycle starting 2 edges after the first accept.
- Flags (`ALU_EX_FLAGS_EN` defined):
  - ADD 0x7FFF+0x0001 → 0x8000, ovf=1, carry=0, zero=0.
  - ADD 0xFFFF+0x0001 → 0x0000, zero=1, carry=1, ovf=0.
  - SUB 0x0003−0x0003 → 0x0000, zero=1, carry=1.
  - Macro undefined: all flags 0.
- Back-pressure: 3 instructions offered, `out_ready`=0 for 4 cycles → `in_ready` drops after 2 accepts; the third is held upstream. On release, 3 results in order with no loss or duplicates, and `out_result` stable throughout the stall.
- Flush: both stages full plus `in_valid`=1 and `flush`=1 → `in_ready`=0 that cycle; next cycle `out_valid`=0 and the offered instruction is not accepted. The next accepted instruction emerges 2 edges later with the correct result.
